// File: rtl/serial_adder_2bit_ctrl.sv
// Multi-cycle adder controller: feeds a 2-bit ripple slice one operand pair
// per clock and assembles the full-width sum, with start/busy/done handshake.
module serial_adder_2bit_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE; the
  // operands and cin are captured on that same edge. busy is high in RUN only,
  // done pulses for exactly one cycle in DONE, and sum/cout hold until the
  // next accepted start.

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [2:0]       slice;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    slice   = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + {2'b00, carry_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Slice k lands directly in bits [2k+1:2k]; same result as shifting in from the top.
        acc_d[2*cnt_q +: 2] = slice[1:0];
        carry_d = slice[2];
        a_sh_d  = a_sh_q >> 2;
        b_sh_d  = b_sh_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = acc_d;
          cout_d  = slice[2];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_2bit_ctrl.sv
// Directed bench for serial_adder_2bit_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_2bit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] st8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;
  logic [1:0] st2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  serial_adder_2bit_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state_o(st8)
  );

  serial_adder_2bit_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .dbg_state_o(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=8 operation with start as a single-cycle pulse.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input string tag);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
    chk({tag, "_busy0"}, busy8, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, "_busy"}, {busy8, done8}, 2'b10);
    end
    step();
    chk({tag, "_done"}, {busy8, done8}, 2'b01);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_cout"}, cout8, ec);
    step();
    chk({tag, "_idle"}, {busy8, done8}, 2'b00);
    chk({tag, "_hold"}, {cout8, sum8}, {ec, es});
  endtask

  initial begin
    logic [2:0] ref3;

    // Reset state
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_state", st8, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: basic add
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t1");
    // 2: full carry ripple
    op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "t2");
    // 3: max operands then zeros, result held between ops
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3a");
    repeat (3) step();
    chk("t3_hold_gap", {cout8, sum8}, 9'h1FF);
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "t3b");

    // 4: start held high, operands changed mid-run
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    step();                                  // E0
    chk("t4_busy0", busy8, 1);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    repeat (3) step();
    chk("t4_still_busy", {busy8, done8}, 2'b10);
    step();                                  // E4
    chk("t4_done1", {busy8, done8}, 2'b01);
    chk("t4_sum1", {cout8, sum8}, 9'h046);
    step();                                  // E5: IDLE even with start high
    chk("t4_idle", {busy8, done8}, 2'b00);
    step();                                  // E6: second op accepted
    chk("t4_busy2", busy8, 1);
    repeat (3) step();
    step();                                  // E10
    chk("t4_done2", {busy8, done8}, 2'b01);
    chk("t4_sum2", {cout8, sum8}, 9'h100);
    start8 = 1'b0;
    step();
    chk("t4_idle2", {busy8, done8}, 2'b00);

    // 5: async reset mid-run
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "t5pre");
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    step();                                  // E0
    start8 = 1'b0;
    step(); step();                          // E2
    chk("t5_pre_sum", sum8, 8'h96);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_bd", {busy8, done8}, 2'b00);
    chk("t5_rst_sum", sum8, 0);
    chk("t5_rst_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_post_idle", {busy8, done8}, 2'b00);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "t5post");

    // 6: WIDTH=2 directed case
    a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1; start2 = 1'b1;
    step();                                  // E0
    start2 = 1'b0;
    chk("t6_busy", {busy2, done2}, 2'b10);
    step();                                  // E1
    chk("t6_done", {busy2, done2}, 2'b01);
    chk("t6_res", {cout2, sum2}, 3'b101);
    step();
    chk("t6_idle", {busy2, done2}, 2'b00);

    // 6: WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a2 = ia[1:0]; b2 = ib[1:0]; cin2 = ic[0]; start2 = 1'b1;
          ref3 = 3'(ia + ib + ic);
          step();
          start2 = 1'b0;
          step();
          chk($sformatf("t6_sw_%0d_%0d_%0d", ia, ib, ic),
              {done2, cout2, sum2}, {1'b1, ref3});
          step();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
